// File: rtl/fifo_byte_streamer_if.sv
// Read side of the trace word FIFO plus the byte stream toward the debug/UART transmitter.
// master = streamer side, slave = FIFO/sink side.
interface fifo_byte_streamer_if #(
  parameter int unsigned WIDTH = 36
) ();

  logic             fifo_empty;
  logic             fifo_pop;
  logic [WIDTH-1:0] fifo_dout;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    input  tx_ready,
    output fifo_pop,
    output tx_data,
    output tx_valid
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    output tx_ready,
    input  fifo_pop,
    input  tx_data,
    input  tx_valid
  );

endinterface

// File: rtl/fifo_byte_streamer.sv
// Pops words from the trace FIFO and sends each as a frame: SYNC byte, then the
// zero-extended word LSB first, on a valid/ready byte stream.
module fifo_byte_streamer #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned BYTES = (WIDTH + 7) / 8,
  parameter logic [7:0]  SYNC  = 8'hA5,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_byte_streamer_if.master bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     word_count
);

  localparam int unsigned SH_W  = 8 * BYTES;
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] HDR  = 2'd2;
  localparam logic [1:0] DATA = 2'd3;

  logic [1:0]       state_q,      state_d;
  logic [SH_W-1:0]  shreg_q,      shreg_d;
  logic [IDX_W-1:0] byte_idx_q,   byte_idx_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;
  logic [7:0]       tx_data_q,    tx_data_d;
  logic             tx_valid_q,   tx_valid_d;
  logic             busy_q,       busy_d;
  logic [SH_W-1:0]  shreg_shift_c;
  logic             handshake_c;
  logic             pop_c;

  assign handshake_c   = tx_valid_q && bus.tx_ready;
  assign shreg_shift_c = shreg_q >> 8;

  // Next-state, pop strobe and next registered stream outputs.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    byte_idx_d   = byte_idx_q;
    word_count_d = word_count_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    pop_c        = 1'b0;

    case (state_q)
      IDLE: begin
        if (!bus.fifo_empty) begin
          pop_c   = 1'b1;
          state_d = LOAD;
        end
      end

      LOAD: begin
        shreg_d    = SH_W'(bus.fifo_dout);
        byte_idx_d = '0;
        tx_valid_d = 1'b1;
        tx_data_d  = SYNC;
        state_d    = HDR;
      end

      HDR: begin
        if (handshake_c) begin
          tx_data_d = shreg_q[7:0];
          state_d   = DATA;
        end
      end

      DATA: begin
        if (handshake_c) begin
          if (byte_idx_q == LAST_IDX) begin
            word_count_d = word_count_q + CNT_W'(1);
            tx_valid_d   = 1'b0;
            // Chain straight into the next word; the LOAD cycle gives the FIFO's
            // registered empty flag time to settle before any further pop.
            if (!bus.fifo_empty) begin
              pop_c   = 1'b1;
              state_d = LOAD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            shreg_d    = shreg_shift_c;
            byte_idx_d = byte_idx_q + IDX_W'(1);
            tx_data_d  = shreg_shift_c[7:0];
          end
        end
      end

      default: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
      end
    endcase

    if (rst) begin
      pop_c = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      byte_idx_q   <= '0;
      word_count_q <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      byte_idx_q   <= byte_idx_d;
      word_count_q <= word_count_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.fifo_pop = pop_c;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign busy         = busy_q;
  assign word_count   = word_count_q;

endmodule

// File: tb/tb_fifo_byte_streamer.sv
// Randomized scoreboard bench for fifo_byte_streamer with a behavioural FIFO and
// a frame-level reference model (SYNC then word bytes LSB first).
module tb_fifo_byte_streamer;

  localparam int unsigned WIDTH = 36;
  localparam int unsigned BYTES = 5;
  localparam int unsigned CNT_W = 4;
  localparam int          FRAME = BYTES + 1;
  localparam logic [7:0]  SYNC  = 8'hA5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             busy;
  logic [CNT_W-1:0] word_count;

  fifo_byte_streamer_if #(.WIDTH(WIDTH)) bif ();

  fifo_byte_streamer #(
    .WIDTH(WIDTH),
    .BYTES(BYTES),
    .SYNC (SYNC),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bif.master),
    .busy      (busy),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural single-clock FIFO: data the cycle after pop, registered empty flag.
  logic [WIDTH-1:0] fq[$];
  always @(posedge clk) begin
    if (bif.fifo_pop) begin
      check("pop_nonempty", 64'(fq.size() != 0), 64'(1));
      if (fq.size() != 0) bif.fifo_dout <= fq.pop_front();
    end
    bif.fifo_empty <= (fq.size() == 0);
  end

  // Sink readiness: always ready, or a coin flip per cycle.
  bit rdy_rand = 1'b0;
  always @(posedge clk) begin
    #1;
    bif.tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Scoreboard / monitor state.
  bit               mon_en      = 1'b0;
  int               cyc         = 0;
  int               pos         = 0;
  int               frames_done = 0;
  int               last_pop_cyc = -100;
  int               sync_cyc    = 0;
  int               last_cyc    = 0;
  int               pop_log[$];
  logic [WIDTH-1:0] exp_words[$];
  logic [CNT_W-1:0] exp_cnt     = '0;
  logic             prev_valid  = 1'b0;
  logic             prev_ready  = 1'b0;
  logic             prev_pop    = 1'b0;
  logic             prev_rst    = 1'b1;
  logic [7:0]       prev_data   = '0;

  always @(negedge clk) begin
    logic [WIDTH-1:0] w;
    logic [7:0]       expb;
    cyc++;
    if (mon_en) begin
      check("word_count", 64'(word_count), 64'(exp_cnt));
      if (prev_valid && !prev_ready && !prev_rst) begin
        check("stall_valid", 64'(bif.tx_valid), 64'(1));
        check("stall_data", 64'(bif.tx_data), 64'(prev_data));
      end
      if (bif.tx_valid && !prev_valid && !prev_rst)
        check("sync_latency", 64'(cyc - last_pop_cyc), 64'(2));
      if (bif.fifo_pop) begin
        check("pop_back_to_back", 64'(prev_pop), 64'(0));
        last_pop_cyc = cyc;
        pop_log.push_back(cyc);
      end
      if (rst) begin
        exp_cnt = '0;
        if (pos != 0) begin
          void'(exp_words.pop_front());
          pos = 0;
        end
      end else if (bif.tx_valid && bif.tx_ready) begin
        if (exp_words.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_byte: got %0h expected no byte", bif.tx_data);
        end else begin
          w    = exp_words[0];
          expb = (pos == 0) ? SYNC : 8'(w >> (8 * (pos - 1)));
          check($sformatf("frame%0d_byte%0d", frames_done, pos), 64'(bif.tx_data), 64'(expb));
          if (pos == 0) sync_cyc = cyc;
          pos++;
          if (pos == FRAME) begin
            void'(exp_words.pop_front());
            pos = 0;
            exp_cnt = exp_cnt + CNT_W'(1);
            frames_done++;
            last_cyc = cyc;
          end
        end
      end
    end
    prev_valid = bif.tx_valid;
    prev_ready = bif.tx_ready;
    prev_pop   = bif.fifo_pop;
    prev_rst   = rst;
    prev_data  = bif.tx_data;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [WIDTH-1:0] w);
    fq.push_back(w);
    exp_words.push_back(w);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (frames_done < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("frame_timeout", 64'(frames_done >= n), 64'(1));
  endtask

  initial begin
    int p0;
    int fd;
    int k;

    rst = 1'b1;
    repeat (3) tick();
    check("rst_tx_valid", 64'(bif.tx_valid), 64'(0));
    check("rst_tx_data", 64'(bif.tx_data), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_word_count", 64'(word_count), 64'(0));
    check("rst_fifo_pop", 64'(bif.fifo_pop), 64'(0));
    mon_en = 1'b1;
    rst = 1'b0;
    repeat (2) tick();

    // Single word, sink always ready.
    p0 = pop_log.size();
    push(36'h9_8765_4321);
    wait_frames(1, 40);
    @(negedge clk);
    #1;
    check("t1_pop_count", 64'(pop_log.size() - p0), 64'(1));
    check("t1_sync_after_pop", 64'(sync_cyc - pop_log[p0]), 64'(2));
    check("t1_frame_span", 64'(last_cyc - sync_cyc), 64'(FRAME - 1));
    check("t1_busy_fall", 64'(busy), 64'(0));
    check("t1_valid_fall", 64'(bif.tx_valid), 64'(0));
    check("t1_word_count", 64'(word_count), 64'(1));

    // Same word with a randomly stalling sink.
    tick();
    rdy_rand = 1'b1;
    push(36'h9_8765_4321);
    wait_frames(2, 300);
    rdy_rand = 1'b0;
    repeat (3) tick();

    // Three preloaded words, back to back.
    p0 = pop_log.size();
    push(36'h0_0000_0001);
    push(36'hF_FFFF_FFFF);
    push(36'h1_2345_6789);
    wait_frames(5, 100);
    @(negedge clk);
    #1;
    check("t3_pop_count", 64'(pop_log.size() - p0), 64'(3));
    check("t3_pop_gap0", 64'(pop_log[p0 + 1] - pop_log[p0]), 64'(7));
    check("t3_pop_gap1", 64'(pop_log[p0 + 2] - pop_log[p0 + 1]), 64'(7));
    check("t3_last_span", 64'(last_cyc - sync_cyc), 64'(FRAME - 1));
    check("t3_word_count", 64'(word_count), 64'(5));
    repeat (2) tick();

    // Empty FIFO for a while, then a late word.
    p0 = pop_log.size();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      check("idle_pop", 64'(bif.fifo_pop), 64'(0));
      check("idle_valid", 64'(bif.tx_valid), 64'(0));
      check("idle_busy", 64'(busy), 64'(0));
    end
    tick();
    push(36'h0_1234_ABCD);
    k = 0;
    while (pop_log.size() == p0 && k < 10) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("late_word_popped", 64'(pop_log.size() - p0), 64'(1));
    wait_frames(6, 40);
    repeat (3) tick();

    // Reset in the middle of a frame, at byte index 2.
    push(36'h5_5AA5_F00D);
    k = 0;
    while (pos != 3 && k < 40) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("reached_byte2", 64'(pos), 64'(3));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", 64'(bif.tx_valid), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_word_count", 64'(word_count), 64'(0));
    fd = frames_done;
    tick();
    push(36'h0_0000_00C3);
    wait_frames(fd + 1, 40);
    repeat (2) tick();

    // Counter wrap with a 4-bit word_count.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fd = frames_done;
    for (int i = 1; i <= 17; i++) begin
      tick();
      push(WIDTH'(i));
      wait_frames(fd + i, 40);
      @(negedge clk);
      #1;
      if (i >= 15) check($sformatf("wrap_after_%0d", i), 64'(word_count), 64'(i % 16));
    end
    repeat (3) tick();
    check("all_words_drained", 64'(exp_words.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
